// File: rtl/dma_copy_64.sv
// dma_copy_64: word-by-word memory copy engine over a 64-word map.
// Each word is read in RD, then written in WR. Every word is checked against
// the region map, and an illegal source or destination aborts the copy.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      copy request, sampled only in IDLE
//   src_i/dst_i  first source / destination word address
//   len_i        word count (0..63)
//   mem_rdata_i  memory read data, combinational from mem_addr_o
//   mem_addr_o   memory address
//   mem_wdata_o  memory write data
//   mem_rw_o     1 = write (level), 0 = read
//   busy_o       copy in progress (RD/WR)
//   done_o       one-cycle completion pulse
//   err_o        sticky abort flag for the last accepted copy
module dma_copy_64 #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW-1:0] len_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_rw_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned RW = 3;  // region field width (top address bits)

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FIN  = 3'd3,
    ABT  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_src_q, cur_src_d;
  logic [AW-1:0] cur_dst_q, cur_dst_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          err_q, err_d;
  logic [RW-1:0] src_rgn, dst_rgn;
  logic          legal;

  // ROM (000, 001) and RAM (010, 100) may be read; only RAM may be written.
  assign src_rgn = cur_src_q[AW-1 -: RW];
  assign dst_rgn = cur_dst_q[AW-1 -: RW];
  assign legal   = (src_rgn inside {3'b000, 3'b001, 3'b010, 3'b100}) &&
                   (dst_rgn inside {3'b010, 3'b100});

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d = 1'b0;
          if (len_i != '0) begin
            cur_src_d = src_i;
            cur_dst_d = dst_i;
            cnt_d     = len_i;
            state_d   = RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      RD: begin
        buf_d = mem_rdata_i;
        if (legal) begin
          state_d = WR;
        end else begin
          err_d   = 1'b1;
          state_d = ABT;
        end
      end
      WR: begin
        // Address increment wraps naturally at the top of the map.
        cur_src_d = cur_src_q + AW'(1);
        cur_dst_d = cur_dst_q + AW'(1);
        cnt_d     = cnt_q - AW'(1);
        state_d   = (cnt_q == AW'(1)) ? FIN : RD;
      end
      FIN:     state_d = IDLE;
      ABT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy_o      = (state_q == RD) || (state_q == WR);
    done_o      = (state_q == FIN) || (state_q == ABT);
    err_o       = err_q;
    mem_addr_o  = (state_q == WR) ? cur_dst_q : cur_src_q;
    mem_wdata_o = buf_q;
    // A reset landing on a WR cycle must not let the level-sensitive memory write.
    mem_rw_o    = (state_q == WR) && !rst_i;
  end

endmodule

// File: doc/dma_copy_64.md
DMA_COPY_64 -- requirements
Module: dma_copy_64

Interface
REQ-001 Parameter DW, default 16, memory data word width.
REQ-002 Parameter AW, default 6, memory address width; 64-word map.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 src  input  AW  first source word address.
REQ-007 dst  input  AW  first destination word address.
REQ-008 len  input  AW  word count, 0..63.
REQ-009 mem_rdata  input  DW  read data from memory; valid combinationally in the same cycle as mem_addr.
REQ-010 mem_addr  output  AW  memory address.
REQ-011 mem_wdata  output  DW  memory write data.
REQ-012 mem_rw  output  1  1 = write, 0 = read; the memory writes on level.
REQ-013 busy  output  1  high in RD and WR states.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  last transfer aborted; sticky.

Function
REQ-016 States SHALL be IDLE, RD, WR, FIN and ABT, held in a registered FSM.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch src, dst and len into cur_src, cur_dst and cnt, clear err, and move to RD.
REQ-018 In IDLE, start=1 with len=0 SHALL clear err and move to FIN with no memory access.
REQ-019 In RD, the block SHALL drive mem_addr=cur_src and mem_rw=0.
- At the clock edge it SHALL capture mem_rdata into buf.
REQ-020 In RD, the block SHALL also check legality at the same edge.
- Source is legal if cur_src[5:3] is 000, 001, 010 or 100.
- Destination is legal only if cur_dst[5:3] is 010 or 100 (RAM).
- Any violation SHALL go to ABT; otherwise the FSM SHALL go to WR.
REQ-021 In WR, the block SHALL drive mem_addr=cur_dst, mem_wdata=buf and mem_rw=1 for exactly one cycle.
REQ-022 At the end of WR, cur_src and cur_dst SHALL increment modulo 64 and cnt SHALL decrement.
- If cnt reaches 0, the FSM SHALL go to FIN; otherwise it SHALL go to RD.
REQ-023 FIN SHALL assert done=1 for one cycle, then return to IDLE.
REQ-024 ABT SHALL assert done=1 and set err=1 for one cycle, then return to IDLE.
- err SHALL remain 1 until the next accepted start or reset.
REQ-025 mem_rw SHALL be 1 only in WR; no write SHALL occur for an aborted word.
REQ-026 start SHALL be ignored while busy=1 or in FIN/ABT.
- src, dst and len SHALL be sampled only at acceptance.
REQ-027 Latency: for len=N with no error, done SHALL be high in the (2N+1)th cycle after the accepting edge.
- For len=0, done SHALL be high in the 1st cycle after the accepting edge.
REQ-028 Address wrap from 0x3F to 0x00 SHALL be performed; legality is rechecked on every word.
REQ-029 Outside WR, mem_wdata SHALL hold buf and mem_addr SHALL hold cur_src.

Reset
REQ-030 On rst=1 at a rising edge, the block SHALL set:
- state=IDLE, busy=0, done=0, err=0, mem_rw=0;
- mem_addr=0, mem_wdata=0, cur_src=cur_dst=cnt=0, buf=0.
REQ-031 Reset asserted in RD or WR SHALL abort the transfer; mem_rw SHALL be 0 from the reset edge onward.
- Words already written SHALL remain; no done pulse SHALL be issued.
REQ-032 Reset SHALL take priority over start in the same cycle.

Verification
REQ-033 Copy ROM to RAM: src=0x02, dst=0x10, len=3 -> RAM 0x10..0x12 = 0xFFFD, 0xFFFC, 0xFFFB; done in cycle 7; err=0.
REQ-034 Illegal destination: src=0x10, dst=0x18, len=2 -> ABT after the first RD, no mem_rw=1 cycle, done=1 with err=1, RAM unchanged.
REQ-035 Region crossing: src=0x0E, dst=0x20, len=4 -> reads 0x0E, 0x0F, 0x10, 0x11 and writes 0x20..0x23; RAM 0x20, 0x21 = 0xFFF1, 0xFFF0; done in cycle 9.
REQ-036 Mid-word abort: src=0x20, dst=0x26, len=4 -> words to 0x26 and 0x27 written; destination 0x28 (101) aborts with err=1.
REQ-037 Degenerate and control cases:
- len=0 -> done in cycle 1, mem_rw stays 0.
- start pulsed while busy -> ignored.
- rst during the second WR of a len=3 copy -> IDLE, one word written, done never pulses.
